mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: state encoding,
// port indices and default bus widths.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 9;

  // Port indices; also the encoding of the last_grant register.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  // Port 0: instruction fetch (read only)
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;

  // Port 1: data (read/write)
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ack;
  logic [DATA_WIDTH-1:0] dm_rdata;

  // RAM side
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_q,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output ram_data, ram_read_addr, ram_write_addr, ram_we, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_q,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  ram_data, ram_read_addr, ram_write_addr, ram_we, busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector. A lone request always wins; on a tie the
// port that was not granted last wins. Output is one-hot (bit 1 = DM port).
module rr_arbiter2 import mem_arb_pkg::*; (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // Pick the winner; nothing is granted while disabled.
  always_comb begin
    grant = 2'b00;
    if (!enable) begin
      grant = 2'b00;
    end else if (req0 && req1) begin
      if (last_grant == PORT_IF) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else begin
      grant = {req1, req0};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialising arbiter giving an instruction-fetch port and a data port
// shared access to a single-ported registered RAM. Every transaction takes
// IDLE -> ACCESS -> DONE, with the ack pulsed in DONE.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  state_e                state_q, state_d;
  logic                  gnt_port_q, gnt_port_d;
  logic                  gnt_we_q, gnt_we_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_we_q, ram_we_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic [1:0]            grant_s;
  logic                  arb_en_s;
  logic                  done_rd_s;

  assign arb_en_s  = (state_q == IDLE);
  assign done_rd_s = (state_q == DONE) && !gnt_we_q;

  rr_arbiter2 u_rr (
    .req0       (bus.if_req),
    .req1       (bus.dm_req),
    .last_grant (last_grant_q),
    .enable     (arb_en_s),
    .grant      (grant_s)
  );

  // RAM drive comes straight from registers; the write enable is also
  // masked by reset so an aborted write never commits on the reset edge.
  assign bus.ram_data       = ram_data_q;
  assign bus.ram_read_addr  = ram_addr_q;
  assign bus.ram_write_addr = ram_addr_q;
  assign bus.ram_we         = ram_we_q & ~reset;
  assign bus.if_ack         = if_ack_q;
  assign bus.dm_ack         = dm_ack_q;
  assign bus.busy           = (state_q != IDLE);

  // The RAM output only becomes valid in DONE, so read data is passed
  // through during the ack cycle and held from a register otherwise.
  assign bus.if_rdata = (done_rd_s && gnt_port_q == PORT_IF) ? bus.ram_q : if_rdata_q;
  assign bus.dm_rdata = (done_rd_s && gnt_port_q == PORT_DM) ? bus.ram_q : dm_rdata_q;

  // Next-state and datapath logic for the three-state transaction FSM.
  always_comb begin
    state_d      = state_q;
    gnt_port_d   = gnt_port_q;
    gnt_we_d     = gnt_we_q;
    last_grant_d = last_grant_q;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    ram_we_d     = 1'b0;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          state_d      = ACCESS;
          gnt_port_d   = grant_s[1];
          last_grant_d = grant_s[1];
          if (grant_s[1]) begin
            ram_addr_d = bus.dm_addr;
            ram_data_d = bus.dm_wdata;
            ram_we_d   = bus.dm_we;
            gnt_we_d   = bus.dm_we;
          end else begin
            ram_addr_d = bus.if_addr;
            ram_we_d   = 1'b0;
            gnt_we_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ACCESS: begin
        state_d = DONE;
        if (gnt_port_q == PORT_DM) begin
          dm_ack_d = 1'b1;
        end else begin
          if_ack_d = 1'b1;
        end
      end

      DONE: begin
        // Requests are deliberately not sampled here; IDLE picks them up.
        state_d = IDLE;
        if (done_rd_s) begin
          if (gnt_port_q == PORT_DM) begin
            dm_rdata_d = bus.ram_q;
          end else begin
            if_rdata_d = bus.ram_q;
          end
        end else begin
          dm_rdata_d = dm_rdata_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_port_q   <= PORT_IF;
      gnt_we_q     <= 1'b0;
      last_grant_q <= PORT_DM;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      ram_we_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      gnt_port_q   <= gnt_port_d;
      gnt_we_q     <= gnt_we_d;
      last_grant_q <= last_grant_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
      ram_we_q     <= ram_we_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

endmodule
